i2s_rx_sequencer: RTL and testbench

Wishbone master that brings up, services and shuts down the I2S receive peripheral on the user-area bus. On enable it writes the prescaler, config and control registers, then polls the status register. It drains RX samples into a one-entry holding register exposed as a valid/ready stream. It is the only bus master driving the peripheral and detects hung bus cycles.

---
 rtl/i2s_seq_pkg.sv | 31 +++
 rtl/i2s_seq_wbm.sv | 87 ++++++++
 rtl/i2s_rx_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_i2s_rx_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_seq_pkg.sv
// Shared types and register map for the I2S RX bring-up/service sequencer.
package i2s_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrPre,
    StWrCfg,
    StWrEn,
    StPoll,
    StGap,
    StRd,
    StDis,
    StErr
  } state_e;

  localparam logic [31:0] DefBaseAddr = 32'h3000_0000;
  localparam logic [7:0]  DefCtrlOff  = 8'h00;
  localparam logic [7:0]  DefPreOff   = 8'h04;
  localparam logic [7:0]  DefCfgOff   = 8'h08;
  localparam logic [7:0]  DefStatOff  = 8'h0C;
  localparam logic [7:0]  DefRxdOff   = 8'h10;

  localparam int unsigned DefEmptyBit = 0;
  localparam logic [31:0] DefCtrlEn   = 32'h0000_0003;
  localparam logic [31:0] CtrlOff     = 32'h0000_0000;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] off);
    return base + {24'h0, off};
  endfunction

endpackage

// File: rtl/i2s_seq_wbm.sv
// Single-transaction Wishbone master: launches one cycle per request, reports ack or timeout.
module i2s_seq_wbm #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  cnt_q, cnt_d;

  always_comb begin
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    done_o    = stb_q & wbm_ack_i;
    timeout_o = 1'b0;
    if (stb_q) begin
      if (wbm_ack_i || cnt_q == TimeoutLast) begin
        // Ack wins over a timeout landing in the same cycle.
        timeout_o = ~wbm_ack_i;
        stb_d     = 1'b0;
        we_d      = 1'b0;
        adr_d     = '0;
        dat_d     = '0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (req_i) begin
      stb_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = we_i ? wdat_i : 32'h0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o    = stb_q;
  assign rdata_o   = wbm_dat_i;
  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = stb_q ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/i2s_rx_sequencer.sv
// Brings up, polls, drains and shuts down the I2S RX peripheral; samples leave on a
// one-entry valid/ready holding register.
module i2s_rx_sequencer
  import i2s_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefBaseAddr,
  parameter logic [7:0]  CTRL_OFF    = DefCtrlOff,
  parameter logic [7:0]  PRE_OFF     = DefPreOff,
  parameter logic [7:0]  CFG_OFF     = DefCfgOff,
  parameter logic [7:0]  STAT_OFF    = DefStatOff,
  parameter logic [7:0]  RXD_OFF     = DefRxdOff,
  parameter int unsigned EMPTY_BIT   = DefEmptyBit,
  parameter logic [31:0] CTRL_EN     = DefCtrlEn,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        enable_i,
  input  logic [7:0]  prescale_i,
  input  logic [31:0] cfg_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        smp_valid_o,
  output logic [31:0] smp_data_o,
  input  logic        smp_ready_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] sample_cnt_o
);

  localparam logic [7:0] GapLast = 8'(POLL_GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  pre_q, pre_d;
  logic [31:0] cfg_q, cfg_d;
  logic        err_q, err_d;
  logic [7:0]  gap_q, gap_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [15:0] scnt_q, scnt_d;

  logic        req, req_we;
  logic [31:0] req_adr, req_dat;
  logic        wb_busy, wb_done, wb_timeout;
  logic [31:0] wb_rdata;

  i2s_seq_wbm #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wbm (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_n_i),
    .req_i    (req),
    .we_i     (req_we),
    .adr_i    (req_adr),
    .wdat_i   (req_dat),
    .busy_o   (wb_busy),
    .done_o   (wb_done),
    .timeout_o(wb_timeout),
    .rdata_o  (wb_rdata),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  always_comb begin
    req_we  = 1'b1;
    req_adr = '0;
    req_dat = '0;
    unique case (state_q)
      StWrPre: begin
        req_adr = reg_addr(BASE_ADDR, PRE_OFF);
        req_dat = {24'h0, pre_q};
      end
      StWrCfg: begin
        req_adr = reg_addr(BASE_ADDR, CFG_OFF);
        req_dat = cfg_q;
      end
      StWrEn: begin
        req_adr = reg_addr(BASE_ADDR, CTRL_OFF);
        req_dat = CTRL_EN;
      end
      StPoll: begin
        req_we  = 1'b0;
        req_adr = reg_addr(BASE_ADDR, STAT_OFF);
      end
      StRd: begin
        req_we  = 1'b0;
        req_adr = reg_addr(BASE_ADDR, RXD_OFF);
      end
      StDis: begin
        req_adr = reg_addr(BASE_ADDR, CTRL_OFF);
        req_dat = CtrlOff;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    gap_d   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    scnt_d  = scnt_q;
    req     = 1'b0;

    if (valid_q && smp_ready_i) begin
      valid_d = 1'b0;
      scnt_d  = scnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          pre_d   = prescale_i;
          cfg_d   = cfg_i;
          err_d   = 1'b0;
          state_d = StWrPre;
        end
      end
      StWrPre, StWrCfg, StWrEn, StPoll, StRd: begin
        if (wb_busy) begin
          if (wb_timeout) begin
            err_d   = 1'b1;
            state_d = StErr;
          end else if (wb_done) begin
            if (!enable_i) begin
              state_d = StDis;
            end else begin
              unique case (state_q)
                StWrPre: state_d = StWrCfg;
                StWrCfg: state_d = StWrEn;
                StWrEn:  state_d = StPoll;
                StPoll: begin
                  // Only read RXD when the holding register is free by the next edge.
                  if (wb_rdata[EMPTY_BIT]) state_d = StGap;
                  else if (!valid_q || smp_ready_i) state_d = StRd;
                  else state_d = StGap;
                end
                default: begin
                  data_d  = wb_rdata;
                  valid_d = 1'b1;
                  state_d = StPoll;
                end
              endcase
            end
          end
        end else if (!enable_i) begin
          state_d = StDis;
        end else begin
          req = 1'b1;
        end
      end
      StGap: begin
        if (!enable_i) state_d = StDis;
        else if (gap_q == GapLast) state_d = StPoll;
        else gap_d = gap_q + 8'd1;
      end
      StDis: begin
        if (wb_busy) begin
          if (wb_timeout) begin
            err_d   = 1'b1;
            state_d = StErr;
          end else if (wb_done) begin
            state_d = StIdle;
          end
        end else begin
          req = 1'b1;
        end
      end
      StErr: begin
        if (!enable_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      pre_q   <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      scnt_q  <= scnt_d;
    end
  end

  assign smp_valid_o  = valid_q;
  assign smp_data_o   = data_q;
  assign busy_o       = (state_q != StIdle);
  assign err_o        = err_q;
  assign sample_cnt_o = scnt_q;

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Scoreboard bench: expected bus transactions and samples are queued by the stimulus,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_i2s_rx_sequencer;

  localparam logic [31:0] Base = 32'h3000_0000;
  localparam logic [31:0] APre = Base + 32'h04;
  localparam logic [31:0] ACfg = Base + 32'h08;
  localparam logic [31:0] ACtl = Base + 32'h00;
  localparam logic [31:0] ASt  = Base + 32'h0C;
  localparam logic [31:0] ARx  = Base + 32'h10;

  logic        clk, rst_n, enable, ack, smp_ready;
  logic [7:0]  prescale;
  logic [31:0] cfg, dat_i;
  logic        cyc, stb, we, smp_valid, busy, err;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, smp_data;
  logic [15:0] scnt;

  i2s_rx_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .enable_i    (enable),
    .prescale_i  (prescale),
    .cfg_i       (cfg),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .smp_valid_o (smp_valid),
    .smp_data_o  (smp_data),
    .smp_ready_i (smp_ready),
    .busy_o      (busy),
    .err_o       (err),
    .sample_cnt_o(scnt)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t        exp_bus[$];
  logic [31:0] exp_smp[$];
  logic [31:0] stat_q[$];
  logic [31:0] rxd_q[$];

  int          n_chk, n_fail, cyc_n;
  bit          strict, gap_chk, nack;
  logic [31:0] nack_adr, stat_default;
  int          rd_cnt, stb_rises, stb_len, last_to_len, last_ack_cyc;
  bit          last_empty_poll, prev_stb, prev_done;
  logic        last_we;
  logic [31:0] last_adr, last_dat, stb_adr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave: single-cycle ack, read data from per-register response queues.
  initial begin
    ack   = 1'b0;
    dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stb && !ack && !(nack && adr == nack_adr)) begin
        ack   = 1'b1;
        dat_i = '0;
        if (!we && adr == ASt) dat_i = (stat_q.size() != 0) ? stat_q.pop_front() : stat_default;
        else if (!we && adr == ARx) dat_i = (rxd_q.size() != 0) ? rxd_q.pop_front() : 32'h0;
      end else begin
        ack   = 1'b0;
        dat_i = '0;
      end
    end
  end

  // Monitor
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stb && !prev_stb) begin
          stb_rises++;
          stb_len = 0;
          stb_adr = adr;
          if (gap_chk && last_ack_cyc >= 0)
            check("txn spacing", 32'(cyc_n - last_ack_cyc), last_empty_poll ? 32'd6 : 32'd2);
        end
        if (stb) stb_len++;
        if (!stb && prev_stb && !prev_done) last_to_len = stb_len;
        if (stb && ack) begin
          check("sel", 32'(sel), 32'hF);
          last_we         = we;
          last_adr        = adr;
          last_dat        = dat_o;
          last_ack_cyc    = cyc_n;
          last_empty_poll = !we && adr == ASt && dat_i[0];
          if (!we && adr == ARx) rd_cnt++;
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check("bus we", 32'(we), 32'(e.we));
            check("bus adr", adr, e.adr);
            if (e.we) check("bus wdata", dat_o, e.dat);
          end else if (strict) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected bus txn: got we=%0b adr=%h, expected none", we, adr);
          end
        end
        if (smp_valid && smp_ready) begin
          if (exp_smp.size() != 0) check("sample data", smp_data, exp_smp.pop_front());
          else begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected sample: got %h, expected none", smp_data);
          end
        end
      end
      prev_stb  = stb && rst_n;
      prev_done = stb && ack;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = 1'b1; t.adr = a; t.dat = d;
    exp_bus.push_back(t);
  endtask

  task automatic push_rd(input logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.adr = a; t.dat = '0;
    exp_bus.push_back(t);
  endtask

  task automatic wait_drain(input int max);
    int i = 0;
    while ((exp_bus.size() != 0 || exp_smp.size() != 0) && i < max) begin
      @(posedge clk);
      i++;
    end
    #2;
    check("queues drained in bound", 32'(exp_bus.size() + exp_smp.size()), 32'd0);
  endtask

  task automatic wait_poll_ack(input int max);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(stb && ack && adr == ASt) && i < max);
    check("poll ack seen in bound", 32'(stb && ack && adr == ASt), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    while (busy && i < max) begin
      @(posedge clk);
      i++;
    end
    #2;
    check("return to idle in bound", 32'(busy), 32'd0);
  endtask

  task automatic check_last_dis();
    check("dis we", 32'(last_we), 32'd1);
    check("dis adr", last_adr, ACtl);
    check("dis data", last_dat, 32'h0);
  endtask

  initial begin
    int r0, s0, i;
    rst_n = 1'b0; enable = 1'b0; smp_ready = 1'b0; prescale = '0; cfg = '0;
    n_chk = 0; n_fail = 0; cyc_n = 0; strict = 1'b1; gap_chk = 1'b0; nack = 1'b0;
    nack_adr = '0; stat_default = 32'h1; rd_cnt = 0; stb_rises = 0; stb_len = 0;
    last_to_len = 0; last_ack_cyc = -1; last_empty_poll = 1'b0; prev_stb = 1'b0;
    prev_done = 1'b0; last_we = 1'b0; last_adr = '0; last_dat = '0; stb_adr = '0;

    step(3);
    check("rst cyc", 32'(cyc), 0);
    check("rst stb", 32'(stb), 0);
    check("rst we", 32'(we), 0);
    check("rst sel", 32'(sel), 0);
    check("rst adr", adr, 0);
    check("rst dat_o", dat_o, 0);
    check("rst smp_valid", 32'(smp_valid), 0);
    check("rst smp_data", smp_data, 0);
    check("rst busy", 32'(busy), 0);
    check("rst err", 32'(err), 0);
    check("rst count", 32'(scnt), 0);
    rst_n = 1'b1;

    // Bring-up, three empty polls, then one sample delivered.
    step(1);
    prescale = 8'h10; cfg = 32'h0000_0005; smp_ready = 1'b1;
    stat_q = '{32'h1, 32'h1, 32'h1, 32'h0};
    rxd_q  = '{32'hDEAD_BEEF};
    push_wr(APre, 32'h10); push_wr(ACfg, 32'h5); push_wr(ACtl, 32'h3);
    push_rd(ASt); push_rd(ASt); push_rd(ASt); push_rd(ASt); push_rd(ARx); push_rd(ASt);
    exp_smp.push_back(32'hDEAD_BEEF);
    gap_chk = 1'b1;
    enable  = 1'b1;
    wait_drain(300);
    gap_chk = 1'b0; strict = 1'b0;
    check("count after first sample", 32'(scnt), 32'd1);
    check("valid dropped after accept", 32'(smp_valid), 32'd0);

    // Held sample blocks further RXD reads until accepted.
    wait_poll_ack(100);
    step(2);
    smp_ready = 1'b0; stat_default = 32'h0;
    rxd_q.push_back(32'h1111_2222);
    exp_smp.push_back(32'h1111_2222);
    i = 0;
    while (!smp_valid && i < 100) begin step(1); i++; end
    check("sample held valid", 32'(smp_valid), 32'd1);
    r0 = rd_cnt;
    step(40);
    check("no RXD read while held", 32'(rd_cnt), 32'(r0));
    check("held data", smp_data, 32'h1111_2222);
    check("count while held", 32'(scnt), 32'd1);
    wait_poll_ack(100);
    step(2);
    stat_default = 32'h1;
    stat_q.push_back(32'h0);
    rxd_q.push_back(32'h3333_4444);
    exp_smp.push_back(32'h3333_4444);
    smp_ready = 1'b1;
    wait_drain(100);
    step(30);
    check("exactly one RXD after accept", 32'(rd_cnt), 32'(r0 + 1));
    check("count after two more", 32'(scnt), 32'd3);

    // Shutdown from polling.
    enable = 1'b0;
    wait_idle(100);
    check_last_dis();

    // WR_CFG never acked: timeout.
    nack = 1'b1; nack_adr = ACfg;
    enable = 1'b1;
    i = 0;
    while (!err && i < 100) begin step(1); i++; end
    step(2);
    check("err after timeout", 32'(err), 32'd1);
    check("stb high cycles", 32'(last_to_len), 32'd16);
    check("timed-out adr", stb_adr, ACfg);
    s0 = stb_rises;
    step(20);
    check("bus idle in ERR", 32'(stb_rises), 32'(s0));
    check("cyc low in ERR", 32'(cyc), 32'd0);
    check("busy in ERR", 32'(busy), 32'd1);
    enable = 1'b0;
    step(3);
    check("idle after ERR", 32'(busy), 32'd0);
    check("err sticky in IDLE", 32'(err), 32'd1);
    nack = 1'b0; prescale = 8'h7F; cfg = 32'hA5A5_0001; strict = 1'b1;
    push_wr(APre, 32'h7F); push_wr(ACfg, 32'hA5A5_0001); push_wr(ACtl, 32'h3); push_rd(ASt);
    enable = 1'b1;
    step(1);
    check("err cleared on restart", 32'(err), 32'd0);
    wait_drain(200);
    strict = 1'b0;

    // Enable dropped during RD: data discarded, then disable write.
    stat_q.push_back(32'h0);
    rxd_q.push_back(32'h5555_6666);
    i = 0;
    do begin @(negedge clk); i++; end while (!(stb && !we && adr == ARx) && i < 200);
    check("RD seen in bound", 32'(stb && !we && adr == ARx), 32'd1);
    enable = 1'b0;
    wait_idle(100);
    check_last_dis();
    check("no valid after discarded RD", 32'(smp_valid), 32'd0);
    check("count unchanged by discard", 32'(scnt), 32'd3);

    // Reset mid-transaction.
    enable = 1'b1;
    i = 0;
    do begin @(negedge clk); i++; end while (!stb && i < 50);
    check("stb before reset", 32'(stb), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst cyc", 32'(cyc), 0);
    check("async rst stb", 32'(stb), 0);
    check("async rst sel", 32'(sel), 0);
    check("async rst adr", adr, 0);
    check("async rst dat_o", dat_o, 0);
    check("async rst busy", 32'(busy), 0);
    check("async rst count", 32'(scnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

endmodule
